// File: rtl/gcbp_pkg.sv
// Shared definitions for the GCBP subimage-store frame ring manager.
package gcbp_pkg;

  localparam int C_STATE_BITS      = 2;
  localparam int C_SLOT_OFFSET_DEF = 128;
  localparam int C_MAX_LINES_DEF   = 64;

  // FILL0/FILL1: ring still priming; RUN: prev/curr valid; PEND: rotation held for the correlator.
  typedef enum logic [C_STATE_BITS-1:0] {
    S_FILL0 = 2'd0,
    S_FILL1 = 2'd1,
    S_RUN   = 2'd2,
    S_PEND  = 2'd3
  } state_e;

  // Ceiling log2, never less than 1 so a slot index always has at least one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/gcbp_slot_ring.sv
// Three-pointer ring over C_NUM_SLOTS slots; each rotation shifts next->curr->prev
// and moves next one slot backwards (mod C_NUM_SLOTS).
module gcbp_slot_ring
  import gcbp_pkg::*;
#(
  parameter int C_NUM_SLOTS = 3,
  parameter int C_SLOT_W    = clog2(C_NUM_SLOTS)
) (
  input  logic                i_clk,
  input  logic                i_resetn,
  input  logic                i_rotate,
  output logic [C_SLOT_W-1:0] o_next_slot,
  output logic [C_SLOT_W-1:0] o_curr_slot,
  output logic [C_SLOT_W-1:0] o_prev_slot
);

  logic [C_SLOT_W-1:0] next_q, curr_q, prev_q;
  logic [C_SLOT_W-1:0] next_d, curr_d, prev_d;

  // Modulo-N decrement: slot 0 wraps to the highest slot index.
  function automatic logic [C_SLOT_W-1:0] dec_mod(input logic [C_SLOT_W-1:0] s);
    if (s == '0) return C_SLOT_W'(C_NUM_SLOTS - 1);
    return s - 1'b1;
  endfunction

  // Next pointer values: hold unless rotating.
  always_comb begin
    next_d = next_q;
    curr_d = curr_q;
    prev_d = prev_q;
    if (i_rotate) begin
      prev_d = curr_q;
      curr_d = next_q;
      next_d = dec_mod(next_q);
    end
  end

  // Pointer registers, reset to next=0, curr=1, prev=2.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      next_q <= C_SLOT_W'(0);
      curr_q <= C_SLOT_W'(1);
      prev_q <= C_SLOT_W'(2);
    end else begin
      next_q <= next_d;
      curr_q <= curr_d;
      prev_q <= prev_d;
    end
  end

  assign o_next_slot = next_q;
  assign o_curr_slot = curr_q;
  assign o_prev_slot = prev_q;

endmodule

// File: rtl/gcbp_frame_ring_mgr.sv
// GCBP frame ring manager: tracks prev/curr/next frame slots in one BRAM,
// holds rotation while the correlator is busy, counts dropped frames and
// generates the registered BRAM write port for incoming lines.
module gcbp_frame_ring_mgr
  import gcbp_pkg::*;
#(
  parameter int C_NUM_SLOTS   = 3,
  parameter int C_SLOT_OFFSET = C_SLOT_OFFSET_DEF,
  parameter int C_LINE_W      = 9,
  parameter int C_ADDR_W      = 9,
  parameter int C_MAX_LINES   = C_MAX_LINES_DEF,
  parameter int C_DROP_W      = 8,
  localparam int C_SLOT_W     = clog2(C_NUM_SLOTS)
) (
  input  logic                i_clk,
  input  logic                i_resetn,
  input  logic [C_LINE_W-1:0] i_line_cnt,
  input  logic                i_line_wr,
  input  logic                i_new_frame,
  input  logic                i_corr_busy,
  output logic [C_SLOT_W-1:0] o_next_slot,
  output logic [C_SLOT_W-1:0] o_curr_slot,
  output logic [C_SLOT_W-1:0] o_prev_slot,
  output logic [C_ADDR_W-1:0] o_bram_write_addr,
  output logic                o_bram_we,
  output logic                o_frame_rotated,
  output logic                o_pair_valid,
  output logic [C_DROP_W-1:0] o_drop_cnt,
  output logic                o_line_ovf
);

  state_e              state_q, state_d;
  logic                rotate;
  logic                drop;
  logic                rotated_q;
  logic [C_DROP_W-1:0] drop_q;
  logic                we_q, we_d;
  logic                ovf_q, ovf_d;
  logic [C_ADDR_W-1:0] addr_q, addr_d;
  logic                line_ok;

  gcbp_slot_ring #(
    .C_NUM_SLOTS (C_NUM_SLOTS),
    .C_SLOT_W    (C_SLOT_W)
  ) u_ring (
    .i_clk       (i_clk),
    .i_resetn    (i_resetn),
    .i_rotate    (rotate),
    .o_next_slot (o_next_slot),
    .o_curr_slot (o_curr_slot),
    .o_prev_slot (o_prev_slot)
  );

  // Rotation/drop decisions; in PEND a busy release wins over a same-cycle new frame.
  always_comb begin
    state_d = state_q;
    rotate  = 1'b0;
    drop    = 1'b0;
    case (state_q)
      S_FILL0: if (i_new_frame) begin rotate = 1'b1; state_d = S_FILL1; end
      S_FILL1: if (i_new_frame) begin rotate = 1'b1; state_d = S_RUN;   end
      S_RUN: begin
        if (i_new_frame) begin
          if (i_corr_busy) state_d = S_PEND;
          else             rotate  = 1'b1;
        end
      end
      S_PEND: begin
        if (!i_corr_busy) begin
          rotate  = 1'b1;
          state_d = S_RUN;
          drop    = i_new_frame;
        end else begin
          drop    = i_new_frame;
        end
      end
      default: state_d = S_FILL0;
    endcase
  end

  // FSM state, rotation pulse and saturating drop counter.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q   <= S_FILL0;
      rotated_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      rotated_q <= rotate;
      if (drop && (drop_q != {C_DROP_W{1'b1}})) drop_q <= drop_q + 1'b1;
    end
  end

  // Write-port next values; the address always uses the pre-rotation next slot.
  always_comb begin
    line_ok = (32'(i_line_cnt) < 32'(C_MAX_LINES));
    we_d    = i_line_wr & line_ok & (state_q != S_PEND);
    ovf_d   = i_line_wr & ~line_ok;
    addr_d  = C_ADDR_W'(32'(o_next_slot) * 32'(C_SLOT_OFFSET) + 32'(i_line_cnt));
  end

  // Registered BRAM write port and line-overflow pulse.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      we_q   <= 1'b0;
      ovf_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      we_q   <= we_d;
      ovf_q  <= ovf_d;
      addr_q <= addr_d;
    end
  end

  assign o_bram_we         = we_q;
  assign o_bram_write_addr = addr_q;
  assign o_line_ovf        = ovf_q;
  assign o_frame_rotated   = rotated_q;
  assign o_drop_cnt        = drop_q;
  assign o_pair_valid      = (state_q == S_RUN) || (state_q == S_PEND);

endmodule
